pc_sequencer: RTL and testbench

- Controls the fetch program counter in the pipelined core: computes next PC, generates PC write enable, and produces pipeline freeze, flush and bubble controls.
- Arbitrates between cache-miss stalls, load-use hazards and branch/jump redirects.
- Sits between the hazard detection unit, the I/D cache controllers and the PC/IF-ID/ID-EX registers.
- Keeps saturating performance counters and raises a sticky memory-timeout error.

---
 rtl/pc_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter control for the pipelined core.
// Picks the next PC and drives PC/IF-ID/ID-EX enables, flush and bubble
// controls. It arbitrates cache-miss stalls, load-use hazards and
// branch/jump redirects. It also keeps saturating performance counters and a
// sticky memory-timeout error flag.
module pc_sequencer #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      pc_cur_i,
    input  logic             icache_stall_i,
    input  logic             dcache_stall_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_target_i,
    output logic [31:0]      pc_next_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    localparam int TO_W = $clog2(TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        MEM_STALL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              err_q, err_d;

    logic              mem_stall;
    logic              active;
    logic [31:0]       pc_inc;

    // Saturating increment: the counters stick at all-ones and never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign mem_stall = icache_stall_i | dcache_stall_i;
    assign active    = (state_q == RUN) || (state_q == MEM_STALL);
    assign pc_inc    = pc_cur_i + 32'd4;

    // Next state and pipeline controls, combinational so they act this cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_d       = state_q;
        pc_next_o     = pc_inc;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        freeze_o      = 1'b0;

        unique case (state_q)
            RUN, MEM_STALL: begin
                if (mem_stall) begin
                    // Cache miss: hold the whole pipeline.
                    freeze_o = 1'b1;
                    state_d  = MEM_STALL;
                end else begin
                    // Leaving MEM_STALL applies the normal controls at once.
                    state_d = RUN;
                    if (load_use_i) begin
                        // Redirects wait; they are seen again next cycle.
                        idex_bubble_o = 1'b1;
                    end else if (jump_i) begin
                        pc_next_o    = jump_target_i;
                        pc_write_o   = 1'b1;
                        ifid_flush_o = 1'b1;
                    end else if (branch_taken_i) begin
                        pc_next_o    = branch_target_i;
                        pc_write_o   = 1'b1;
                        ifid_flush_o = 1'b1;
                    end else begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                    end
                end
            end
            default: begin
                // IDLE (and the unused encoding): hold PC at 0 and flush IF/ID.
                pc_next_o    = 32'd0;
                pc_write_o   = 1'b1;
                ifid_flush_o = 1'b1;
                state_d      = start_i ? RUN : IDLE;
            end
        endcase

        if (!start_i) begin
            state_d = IDLE;
        end
    end

    // Counter, timeout and error next-state values. Only cycles outside IDLE
    // count, so the idle flush that parks the pipeline does not inflate
    // flush_cnt.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        to_cnt_d    = '0;
        err_d       = err_q;

        if (active) begin
            cycle_cnt_d = sat_inc(cycle_cnt_q);
            if (freeze_o || idex_bubble_o) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
            if (ifid_flush_o) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end
        end

        if (state_q == MEM_STALL) begin
            // The timeout counter runs only while we stay in MEM_STALL.
            if (state_d == MEM_STALL) begin
                to_cnt_d = (to_cnt_q < TO_LAST) ? to_cnt_q + TO_W'(1) : to_cnt_q;
            end
            if (mem_stall && (to_cnt_q == TO_LAST)) begin
                err_d = 1'b1;
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers see pre-edge values.
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            to_cnt_q    <= to_cnt_d;
            err_q       <= err_d;
        end
    end

    assign state_o     = state_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with hand-computed expectations for
// pc_sequencer. A second instance with 3-bit counters covers saturation.
module tb_pc_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_cur_i;
    logic        icache_stall_i;
    logic        dcache_stall_i;
    logic        load_use_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;

    logic [31:0] pc_next_o;
    logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, freeze_o, err_o;
    logic [1:0]  state_o;
    logic [31:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o;

    logic [31:0] s_pc_next;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_freeze, s_err;
    logic [1:0]  s_state;
    logic [2:0]  s_cycle_cnt, s_stall_cnt, s_flush_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    pc_sequencer #(.TIMEOUT(8), .CNT_W(32)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_cur_i(pc_cur_i),
        .icache_stall_i(icache_stall_i), .dcache_stall_i(dcache_stall_i),
        .load_use_i(load_use_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
        .pc_next_o(pc_next_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
        .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o), .freeze_o(freeze_o),
        .state_o(state_o), .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o), .err_o(err_o)
    );

    pc_sequencer #(.TIMEOUT(8), .CNT_W(3)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_cur_i(pc_cur_i),
        .icache_stall_i(icache_stall_i), .dcache_stall_i(dcache_stall_i),
        .load_use_i(load_use_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
        .pc_next_o(s_pc_next), .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write),
        .ifid_flush_o(s_ifid_flush), .idex_bubble_o(s_idex_bubble), .freeze_o(s_freeze),
        .state_o(s_state), .cycle_cnt_o(s_cycle_cnt), .stall_cnt_o(s_stall_cnt),
        .flush_cnt_o(s_flush_cnt), .err_o(s_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; pc_cur_i = '0;
        icache_stall_i = 1'b0; dcache_stall_i = 1'b0; load_use_i = 1'b0;
        branch_taken_i = 1'b0; branch_target_i = '0; jump_i = 1'b0; jump_target_i = '0;
        settle();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_cycle_cnt", cycle_cnt_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_pc_next", pc_next_o, 32'd0);
        check("rst_pc_write", 32'(pc_write_o), 32'd1);

        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        // Start from IDLE, then run sequentially.
        start_i = 1'b1; pc_cur_i = 32'h0;
        settle();
        check("idle_state", 32'(state_o), 32'd0);
        check("idle_pc_next", pc_next_o, 32'd0);
        check("idle_flush", 32'(ifid_flush_o), 32'd1);
        check("idle_ifid_write", 32'(ifid_write_o), 32'd0);
        tick();
        check("run_state", 32'(state_o), 32'd1);
        check("run_pc_next", pc_next_o, 32'd4);
        check("run_ifid_write", 32'(ifid_write_o), 32'd1);
        check("run_cycle0", cycle_cnt_o, 32'd0);
        tick();
        check("run_cycle1", cycle_cnt_o, 32'd1);
        tick();
        check("run_cycle2", cycle_cnt_o, 32'd2);
        check("idle_no_flush_count", flush_cnt_o, 32'd0);

        // Taken branch.
        pc_cur_i = 32'h100; branch_taken_i = 1'b1; branch_target_i = 32'h200;
        settle();
        check("br_pc_next", pc_next_o, 32'h200);
        check("br_flush", 32'(ifid_flush_o), 32'd1);
        check("br_pc_write", 32'(pc_write_o), 32'd1);
        tick();
        branch_taken_i = 1'b0;
        settle();
        check("br_flush_cnt", flush_cnt_o, 32'd1);
        check("br_after_pc_next", pc_next_o, 32'h104);

        // Jump beats branch.
        jump_i = 1'b1; jump_target_i = 32'h300; branch_taken_i = 1'b1;
        settle();
        check("jmp_pc_next", pc_next_o, 32'h300);
        tick();
        jump_i = 1'b0; branch_taken_i = 1'b0;
        settle();
        check("jmp_flush_cnt", flush_cnt_o, 32'd2);

        // Load-use suppresses a simultaneous branch, which applies next cycle.
        load_use_i = 1'b1; branch_taken_i = 1'b1;
        settle();
        check("lu_pc_write", 32'(pc_write_o), 32'd0);
        check("lu_bubble", 32'(idex_bubble_o), 32'd1);
        check("lu_no_flush", 32'(ifid_flush_o), 32'd0);
        check("lu_ifid_write", 32'(ifid_write_o), 32'd0);
        tick();
        load_use_i = 1'b0;
        settle();
        check("lu_redirect_pc", pc_next_o, 32'h200);
        check("lu_redirect_flush", 32'(ifid_flush_o), 32'd1);
        check("lu_stall_cnt", stall_cnt_o, 32'd1);
        tick();
        branch_taken_i = 1'b0;
        settle();
        check("lu_flush_cnt", flush_cnt_o, 32'd3);

        // Five-cycle data cache miss.
        pc_cur_i = 32'h104; dcache_stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("dc_freeze", 32'(freeze_o), 32'd1);
            check("dc_pc_write", 32'(pc_write_o), 32'd0);
            check("dc_state", 32'(state_o), (i == 0) ? 32'd1 : 32'd2);
            tick();
        end
        dcache_stall_i = 1'b0;
        settle();
        check("dc_rel_state", 32'(state_o), 32'd2);
        check("dc_rel_pc_write", 32'(pc_write_o), 32'd1);
        check("dc_rel_pc_next", pc_next_o, 32'h108);
        check("dc_rel_freeze", 32'(freeze_o), 32'd0);
        check("dc_stall_cnt", stall_cnt_o, 32'd6);
        tick();
        check("dc_back_run", 32'(state_o), 32'd1);
        check("dc_no_err", 32'(err_o), 32'd0);

        // Instruction cache miss for 20 cycles: err after the 8th MEM_STALL cycle.
        icache_stall_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("to_err", 32'(err_o), (k >= 9) ? 32'd1 : 32'd0);
        end
        check("to_still_stalled", 32'(state_o), 32'd2);
        icache_stall_i = 1'b0;
        tick();
        check("to_recover_run", 32'(state_o), 32'd1);
        check("to_err_sticky1", 32'(err_o), 32'd1);
        start_i = 1'b0;
        tick();
        check("to_idle", 32'(state_o), 32'd0);
        check("to_err_sticky2", 32'(err_o), 32'd1);
        start_i = 1'b1;
        tick();
        check("to_err_sticky3", 32'(err_o), 32'd1);

        // Drop start in the middle of a stall.
        dcache_stall_i = 1'b1;
        tick();
        tick();
        start_i = 1'b0;
        settle();
        check("ds_state", 32'(state_o), 32'd2);
        check("ds_freeze", 32'(freeze_o), 32'd1);
        tick();
        dcache_stall_i = 1'b0;
        settle();
        check("ds_idle", 32'(state_o), 32'd0);
        check("ds_pc_next", pc_next_o, 32'd0);

        // PC wrap.
        start_i = 1'b1;
        tick();
        pc_cur_i = 32'hFFFF_FFFC;
        settle();
        check("wrap_pc_next", pc_next_o, 32'd0);
        tick();

        // Asynchronous reset in the middle of RUN.
        #2;
        rst_i = 1'b0;
        settle();
        check("ar_state", 32'(state_o), 32'd0);
        check("ar_cycle_cnt", cycle_cnt_o, 32'd0);
        check("ar_stall_cnt", stall_cnt_o, 32'd0);
        check("ar_flush_cnt", flush_cnt_o, 32'd0);
        check("ar_err", 32'(err_o), 32'd0);
        check("ar_pc_next", pc_next_o, 32'd0);

        // Saturation: 10 RUN cycles on a 3-bit counter stick at 7.
        pc_cur_i = 32'h0;
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check("sat_cycle_cnt", 32'(s_cycle_cnt), 32'd7);
        check("nosat_cycle_cnt", cycle_cnt_o, 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
